// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor, A - B - Bin, LSB first
// Optional signed-overflow output s_Ovf enabled by defining SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_A,
  input  logic [WIDTH-1:0] s_B,
  input  logic             s_Bin,
  input  logic             s_start,
  output logic             s_busy,
  output logic             s_done,
  output logic [WIDTH-1:0] s_Diff,
  output logic             s_Bout
`ifdef SUB_OVF_EN
  ,
  output logic             s_Ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic start_ok;
  logic last_bit;
  logic bit_d;
  logic br_next;
  logic unused_res_lsb;

  assign start_ok       = s_start && (state_q != SHIFT);
  assign last_bit       = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign bit_d          = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next        = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  // The oldest result bit falls off the end of the shift register by design.
  assign unused_res_lsb = res_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start_ok ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    diff_d = diff_q;
    br_d   = br_q;
    bout_d = bout_q;
    cnt_d  = cnt_q;
    if (start_ok) begin
      a_d   = s_A;
      b_d   = s_B;
      br_d  = s_Bin;
      cnt_d = '0;
      res_d = '0;
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_next;
      cnt_d = cnt_q + CW'(1);
      res_d = {bit_d, res_q[WIDTH-1:1]};
      if (last_bit) begin
        diff_d = {bit_d, res_q[WIDTH-1:1]};
        bout_d = br_next;
      end
    end
  end

`ifdef SUB_OVF_EN
  // Operand MSBs are kept aside because the operand registers shift them away.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (start_ok) begin
      a_msb_d = s_A[WIDTH-1];
      b_msb_d = s_B[WIDTH-1];
    end else if (last_bit) begin
      ovf_d = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
    end
  end

  assign s_Ovf = ovf_q;
`endif

  always_comb begin
    s_busy = (state_q == SHIFT);
    s_done = (state_q == DONE);
    s_Diff = diff_q;
    s_Bout = bout_q;
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard bench for serial_sub (WIDTH=8)
module tb_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_A, s_B;
  logic         s_Bin, s_start;
  logic         s_busy, s_done, s_Bout;
  logic [W-1:0] s_Diff;
`ifdef SUB_OVF_EN
  logic         s_Ovf;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_A     (s_A),
    .s_B     (s_B),
    .s_Bin   (s_Bin),
    .s_start (s_start),
    .s_busy  (s_busy),
    .s_done  (s_done),
    .s_Diff  (s_Diff),
    .s_Bout  (s_Bout)
`ifdef SUB_OVF_EN
    ,
    .s_Ovf   (s_Ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit track);
    logic [W:0] r;
    exp_t       e;
    s_A     = a;
    s_B     = b;
    s_Bin   = bin;
    s_start = 1'b1;
    if (track) begin
      r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      e.diff = r[W-1:0];
      e.bout = r[W];
      e.ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      e.due  = cyc + 1 + W;
      q.push_back(e);
    end
    step();
    s_start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      step();
    end
    chk("pending_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (s_done) break;
      step();
    end
    chk("done_wait", s_done, 1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_diff = '0;
      last_bout = 1'b0;
    end else begin
      chk("busy_done_excl", s_busy && s_done, 0);
      if (s_done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=done_pulse required=none (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("diff", s_Diff, e.diff);
          chk("bout", s_Bout, e.bout);
          chk("done_latency", cyc, e.due);
`ifdef SUB_OVF_EN
          chk("ovf", s_Ovf, e.ovf);
`endif
          last_diff = e.diff;
          last_bout = e.bout;
        end
      end else begin
        chk("diff_hold", s_Diff, last_diff);
        chk("bout_hold", s_Bout, last_bout);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    s_A = '0;
    s_B = '0;
    s_Bin = 1'b0;
    s_start = 1'b0;
    step();
    step();
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_diff", s_Diff, 0);
    chk("rst_bout", s_Bout, 0);
    rst = 1'b0;

    issue(8'h03, 8'h01, 1'b0, 1'b1);
    wait_empty();

    issue(8'h05, 8'h02, 1'b0, 1'b1);
    wait_done();
    issue(8'h00, 8'h00, 1'b1, 1'b1);
    chk("b2b_busy", s_busy, 1);
    wait_empty();

    issue(8'h5A, 8'h5A, 1'b0, 1'b1);
    wait_empty();
    issue(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_empty();
    issue(8'h00, 8'hFF, 1'b0, 1'b1);
    wait_empty();
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    wait_empty();
    issue(8'h7F, 8'hFF, 1'b0, 1'b1);
    wait_empty();

    issue(8'h10, 8'h01, 1'b0, 1'b1);
    step();
    step();
    issue(8'hAA, 8'h55, 1'b0, 1'b0);
    wait_empty();
    repeat (12) step();

    issue(8'h20, 8'h10, 1'b0, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_busy", s_busy, 0);
    chk("midrst_done", s_done, 0);
    chk("midrst_diff", s_Diff, 0);
    chk("midrst_bout", s_Bout, 0);
    step();
    rst = 1'b0;
    issue(8'h20, 8'h10, 1'b0, 1'b1);
    wait_empty();

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) step();
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      wait_empty();
    end
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
